// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin burst arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Index width that never collapses to zero, so two channels still get a 1-bit index.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned max_burst);
      return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Channel request/urgent/transfer bundle and the grant it produces.
interface rr_burst_arbiter_if
   import arb_pkg::*;
#(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned MAX_BURST = 16
) ();
   localparam int unsigned IW = idx_w(NUM_CH);
   localparam int unsigned CW = cnt_w(MAX_BURST);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] urgent;
   logic              xfer;
   logic              grant_valid;
   logic [IW-1:0]     grant;
   logic [CW-1:0]     burst_cnt;

   modport master (output req, urgent, xfer, input grant_valid, grant, burst_cnt);
   modport slave  (input req, urgent, xfer, output grant_valid, grant, burst_cnt);
endinterface

// File: rtl/rr_burst_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of mask strictly after ptr, wrapping, ptr itself last.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned NUM_CH = 8
) (
   input  logic [NUM_CH-1:0]         mask,
   input  logic [idx_w(NUM_CH)-1:0]  ptr,
   output logic [idx_w(NUM_CH)-1:0]  idx,
   output logic                      found
);
   localparam int unsigned IW = idx_w(NUM_CH);
   localparam int unsigned PW = idx_w(2 * NUM_CH);

   logic [NUM_CH-1:0]   upper;
   logic [2*NUM_CH-1:0] dbl;
   logic [PW-1:0]       pos;

   // Low half keeps only bits above ptr; high half is the full mask for the wrapped pass.
   always_comb begin
      upper = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         upper[i] = (i > int'(ptr));
      end
      dbl   = {mask, mask & upper};
      pos   = '0;
      found = 1'b0;
      for (int i = 2 * int'(NUM_CH) - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            pos   = PW'(i);
            found = 1'b1;
         end
      end
      idx = (pos >= PW'(NUM_CH)) ? IW'(pos - PW'(NUM_CH)) : IW'(pos);
   end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin, urgent-first arbiter granting bounded bursts of the upstream bus to RX FIFOs.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned MAX_BURST = 16,
   parameter bit          PREEMPT   = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   rr_burst_arbiter_if.slave  bus
);
   localparam int unsigned IW = idx_w(NUM_CH);
   localparam int unsigned CW = cnt_w(MAX_BURST);

   arb_state_t        state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [NUM_CH-1:0] urg_req;
   logic [NUM_CH-1:0] cand;
   logic [NUM_CH-1:0] others_urg;
   logic [IW-1:0]     pick_idx;
   logic              pick_found;
   logic              release_c;

   // Urgent requesters, if any, shadow the plain request set.
   assign urg_req = bus.urgent & bus.req;
   assign cand    = (|urg_req) ? urg_req : bus.req;

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .mask  (cand),
      .ptr   (last_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      others_urg = urg_req & ~(NUM_CH'(1) << grant_q);
      release_c  = !bus.req[grant_q]
                || (bus.xfer && (cnt_q == CW'(MAX_BURST - 1)))
                || (PREEMPT && !bus.urgent[grant_q] && (|others_urg));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_CH - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // IDLE always lasts at least one cycle: it is the mux-switch bubble between grants.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = HOLD;
               grant_d = pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (bus.xfer) cnt_d = cnt_q + CW'(1);
            if (release_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.grant_valid = (state_q == HOLD);
   assign bus.grant       = grant_q;
   assign bus.burst_cnt   = cnt_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized check of three arbiter configurations against an arithmetic reference model.
module tb_rr_burst_arbiter;
   import arb_pkg::*;

   typedef struct {
      bit hold;
      int grant;
      int last;
      int cnt;
   } mdl_t;

   logic        clk;
   logic        rst;
   logic [31:0] req_v;
   logic [31:0] urg_v;
   logic        xfer_v;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mdl_t m [3];
   int   nch [3] = '{8, 8, 2};
   int   mbl [3] = '{4, 4, 1};
   bit   pre [3] = '{1'b1, 1'b0, 1'b1};
   int   obs_v [3];
   int   obs_g [3];
   int   obs_c [3];

   rr_burst_arbiter_if #(.NUM_CH(8), .MAX_BURST(4)) bus0 ();
   rr_burst_arbiter_if #(.NUM_CH(8), .MAX_BURST(4)) bus1 ();
   rr_burst_arbiter_if #(.NUM_CH(2), .MAX_BURST(1)) bus2 ();

   assign bus0.req    = req_v[7:0];
   assign bus0.urgent = urg_v[7:0];
   assign bus0.xfer   = xfer_v;
   assign bus1.req    = req_v[7:0];
   assign bus1.urgent = urg_v[7:0];
   assign bus1.xfer   = xfer_v;
   assign bus2.req    = req_v[1:0];
   assign bus2.urgent = urg_v[1:0];
   assign bus2.xfer   = xfer_v;

   rr_burst_arbiter #(.NUM_CH(8), .MAX_BURST(4), .PREEMPT(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   rr_burst_arbiter #(.NUM_CH(8), .MAX_BURST(4), .PREEMPT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   rr_burst_arbiter #(.NUM_CH(2), .MAX_BURST(1), .PREEMPT(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Next model state after one clock, straight from the grant/release rules.
   function automatic mdl_t mdl_step(input mdl_t cur, input bit r, input bit [31:0] rq_in,
                                     input bit [31:0] ug_in, input bit x, input int n,
                                     input int mb, input bit pe);
      mdl_t     nx;
      bit [31:0] rq, ug, uq, cand;
      bit        rel, done;
      nx = cur;
      if (r) begin
         nx.hold = 1'b0; nx.grant = 0; nx.last = n - 1; nx.cnt = 0;
         return nx;
      end
      rq = '0; ug = '0;
      for (int b = 0; b < n; b++) begin
         rq[b] = rq_in[b];
         ug[b] = ug_in[b];
      end
      uq   = rq & ug;
      cand = (uq != 0) ? uq : rq;
      if (!cur.hold) begin
         done = 1'b0;
         for (int k = 1; k <= n; k++) begin
            int c;
            c = (cur.last + k) % n;
            if (!done && cand[c]) begin
               done = 1'b1;
               nx.hold = 1'b1; nx.grant = c; nx.last = c; nx.cnt = 0;
            end
         end
      end else begin
         if (x) nx.cnt = cur.cnt + 1;
         rel = !rq[cur.grant] || (x && cur.cnt == mb - 1);
         if (pe && !ug[cur.grant]) begin
            for (int b = 0; b < n; b++)
               if (b != cur.grant && uq[b]) rel = 1'b1;
         end
         if (rel) nx.hold = 1'b0;
      end
      return nx;
   endfunction

   task automatic sample();
      obs_v[0] = int'(bus0.grant_valid); obs_g[0] = int'(bus0.grant); obs_c[0] = int'(bus0.burst_cnt);
      obs_v[1] = int'(bus1.grant_valid); obs_g[1] = int'(bus1.grant); obs_c[1] = int'(bus1.burst_cnt);
      obs_v[2] = int'(bus2.grant_valid); obs_g[2] = int'(bus2.grant); obs_c[2] = int'(bus2.burst_cnt);
   endtask

   // Drive one cycle at the falling edge, clock it, then compare every DUT with its model.
   task automatic step_cycle(input bit r, input bit [31:0] rq, input bit [31:0] ug, input bit x);
      rst = r; req_v = rq; urg_v = ug; xfer_v = x;
      for (int i = 0; i < 3; i++)
         m[i] = mdl_step(m[i], r, rq, ug, x, nch[i], mbl[i], pre[i]);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sample();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("d%0d_valid@%0d", i, cyc), obs_v[i], int'(m[i].hold));
         check($sformatf("d%0d_grant@%0d", i, cyc), obs_g[i], m[i].grant);
         check($sformatf("d%0d_cnt@%0d", i, cyc), obs_c[i], m[i].cnt);
      end
   endtask

   initial begin
      bit [31:0] rq, ug;
      bit        x, r;
      int        g0, g2, pv0, pv2;
      rst = 1'b1; req_v = 32'hFF; urg_v = '0; xfer_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m[i].hold = 1'b0; m[i].grant = 0; m[i].last = 0; m[i].cnt = 0;
      end

      for (int c = 0; c < 3; c++) begin
         step_cycle(1'b1, 32'hFF, 32'h0, 1'b1);
         check("rst_valid", obs_v[0], 0);
      end

      // Fairness: everyone requests, every cycle transfers.
      g0 = 0; g2 = 0; pv0 = 0; pv2 = 0;
      for (int c = 0; c < 50; c++) begin
         step_cycle(1'b0, 32'hFF, 32'h0, 1'b1);
         if (c == 0) begin
            check("first_valid", obs_v[0], 1);
            check("first_grant", obs_g[0], 0);
         end
         if (obs_v[0] == 1 && pv0 == 0) begin
            check("fair_grant8", obs_g[0], g0 % 8);
            g0++;
         end
         if (obs_v[0] == 0) check("fair_gap_cnt8", obs_c[0], 4);
         if (obs_v[2] == 1 && pv2 == 0) begin
            check("fair_grant2", obs_g[2], g2 % 2);
            g2++;
         end
         if (obs_v[2] == 0) check("fair_gap_cnt2", obs_c[2], 1);
         pv0 = obs_v[0];
         pv2 = obs_v[2];
      end
      check("fair_grants8", g0, 10);

      // Random: slowly toggling requests, rare urgents, occasional reset.
      rq = 32'hFF; ug = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(7) == 0)  rq[b] = ~rq[b];
            if ($urandom_range(15) == 0) ug[b] = ~ug[b];
         end
         x = ($urandom_range(3) != 0);
         r = ($urandom_range(299) == 0);
         step_cycle(r, rq, ug, x);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Parametrised round-robin arbiter that selects which peripheral RX FIFO owns the FT601 upstream bus, replacing the fixed 8-channel arbiter. It adds four features:
- a configurable channel count;
- urgent-first selection driven by per-channel almost-full flags;
- a bounded burst length per grant;
- optional preemption of a non-urgent grant.

It sits between the peripheral RX FIFOs and the FT601 read mux, and drives the mux select plus a valid qualifier.

## Interface
Parameters:
- NUM_CH, 8: number of peripheral channels, 2..32.
- MAX_BURST, 16: maximum words transferred per grant, 1..255.
- PREEMPT, 1: when 1, a newly urgent channel forces release of a non-urgent grant.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  NUM_CH  active-high request per channel (RX FIFO not empty).
- urgent  input  NUM_CH  active-high urgent flag per channel (RX FIFO almost full).
- xfer  input  1  one word read from the granted channel this cycle.
- grant_valid  output  1  grant is held and the mux select is stable.
- grant  output  $clog2(NUM_CH)  index of the granted channel.
- burst_cnt  output  $clog2(MAX_BURST+1)  words transferred in the current grant.

## Operation
- State machine with two states:
  - IDLE: grant_valid=0.
  - HOLD: grant_valid=1.
- Round-robin pointer `last`: index of the most recently granted channel.
  - Reset value NUM_CH-1, so channel 0 wins first.
- Candidate set for selection:
  - If urgent & req is non-zero, the set is urgent & req.
  - Otherwise the set is req.
  - An urgent flag without req is ignored.
- Selection picks the first set bit scanning last+1, last+2, …, wrapping modulo NUM_CH. `last` itself is checked last.
- IDLE → HOLD when the candidate set is non-zero. On that transition:
  - grant ← selected index;
  - last ← selected index;
  - burst_cnt ← 0.
- In HOLD, each cycle with xfer=1 increments burst_cnt.
- HOLD → IDLE, evaluated every HOLD cycle; any one condition releases:
  - (a) req[grant]=0, i.e. the FIFO drained.
  - (b) xfer=1 and burst_cnt=MAX_BURST-1, i.e. the burst limit is reached on that word.
  - (c) PREEMPT=1, urgent[grant]=0, and any other channel has urgent & req set.
- xfer while grant_valid=0 is ignored: no count change, no error.
- grant keeps its last value in IDLE. Only grant_valid qualifies it.
- burst_cnt keeps its final value in IDLE and clears on the next grant.
- Reset mid-burst immediately returns all state to reset values. No grant survives reset.

## Timing
- Reset values: grant_valid=0, grant=0, burst_cnt=0, state IDLE, last=NUM_CH-1.
- Request sampled in IDLE at cycle t → grant_valid=1 with grant stable at t+1.
- Release condition true at cycle t → grant_valid=0 at t+1. IDLE lasts exactly one cycle, and the next grant is visible at t+2 at the earliest. The one-cycle gap is a mandatory mux-switch bubble.
- The release cycle's xfer is counted: burst_cnt at t+1 includes it.
- With MAX_BURST=1, a grant ends after its first xfer.
- All outputs are registered. The only combinational path is req/urgent → next-state.

## Structure
- Package arb_pkg holds:
  - state enum arb_state_t {IDLE, HOLD};
  - function clog2-safe width helpers, so that NUM_CH=2 still gives a 1-bit grant.
- Sub-module rr_pick is a combinational rotating priority encoder:
  - parameter NUM_CH;
  - inputs mask[NUM_CH] and ptr;
  - outputs idx and found.
  - Implement it as double-width concatenation plus a fixed priority encoder. No barrel shifter plus adder.
- rr_burst_arbiter holds the FSM, `last`, the burst counter, and the release logic.

## Test plan
All scenarios use NUM_CH=8, MAX_BURST=4, PREEMPT=1 unless stated.
- Reset: hold rst 3 cycles with req=8'hFF → grant_valid=0 throughout. First grant after release is channel 0, with grant_valid high 1 cycle after rst falls.
- Fairness: req=8'hFF constant, xfer=1 constant → grants 0,1,2,…,7,0. Each grant lasts exactly 4 HOLD cycles with a 1-cycle IDLE gap between grants. burst_cnt reads 4 in each gap.
- Drain release: req=8'b0000_0100 → grant=2. Drop req[2] after 2 xfers → grant_valid=0 next cycle and burst_cnt=2. The next grant goes to any new requester after 2, wrapping.
- Urgent priority: last=3, req=8'hFF, urgent=8'b0000_0010 → grant=1, even though 4 is next in round-robin order. urgent=8'b0000_0010 with req[1]=0 → grant=4.
- Preemption: grant=5 non-urgent. Raise urgent[6] with req[6]=1 → grant_valid drops 1 cycle later, then grant=6. Repeat with PREEMPT=0 → channel 5 keeps the grant until its burst limit or drain.
- Wrap and width: NUM_CH=2, MAX_BURST=1, req=2'b11, xfer=1 → grant alternates 0,1,0 with 1-cycle HOLD and 1-cycle IDLE. grant is 1 bit wide.
